// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 BCM scan driver.
package hub75_pkg;

  // Top-level scan phases.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    LATCH   = 2'd2,
    DISPLAY = 2'd3
  } state_e;

  // Colour-field index inside the pixel-pair word {r1,g1,b1,r0,g0,b0}.
  // Field f occupies bits [f*DEPTH +: DEPTH].
  localparam int FLD_B0 = 0;
  localparam int FLD_G0 = 1;
  localparam int FLD_R0 = 2;
  localparam int FLD_B1 = 3;
  localparam int FLD_G1 = 4;
  localparam int FLD_R1 = 5;

  // OE-active cycles for a bit plane: each plane doubles the weight of the previous one.
  function automatic int disp_ticks(input int base, input int plane);
    return base << plane;
  endfunction

endpackage

// File: rtl/hub75_col_shifter.sv
// Column shifter: walks one row of pixel pairs per SHIFT phase. Issues the
// framebuffer address two cycles per column, captures the selected bit plane
// from the registered RAM output and pulses sclk mid-way through each data
// window. Valid/ready semantics do not apply: the RAM always answers one cycle
// after the address, so the schedule is fixed and needs no handshake.
module hub75_col_shifter
  import hub75_pkg::*;
#(
  parameter int COLS     = 64,
  parameter int DEPTH    = 4,
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 6,
  parameter int PLANE_W  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_in_shift,    // FSM is in SHIFT this cycle
  input  logic                         i_shift_next,  // FSM will be in SHIFT next cycle
  input  logic [ROW_BITS-1:0]          i_row_next,
  input  logic [PLANE_W-1:0]           i_plane,
  input  logic [6*DEPTH-1:0]           i_rdata,
  output logic [ROW_BITS+COL_BITS-1:0] o_fb_addr,
  output logic                         o_sclk,
  output logic [2:0]                   o_rgb0,
  output logic [2:0]                   o_rgb1,
  output logic                         o_done
);

  localparam int K_W = $clog2(2 * COLS + 2);
  localparam logic [K_W-1:0] K_COLS2 = K_W'(2 * COLS);
  localparam logic [K_W-1:0] K_LAST  = K_W'(2 * COLS + 1);
  localparam logic [K_W-1:0] K_SCLK0 = K_W'(3);

  logic [K_W-1:0] r_k;
  logic [K_W-1:0] w_k_next;
  logic [5:0]     w_bits;

  // Index of the next SHIFT cycle; restarts at 0 whenever SHIFT is (re)entered.
  always_comb begin
    w_k_next = '0;
    if (i_shift_next && i_in_shift) w_k_next = r_k + K_W'(1);
  end

  // Pick bit i_plane out of each of the six colour fields.
  always_comb begin
    w_bits = '0;
    for (int f = 0; f < 6; f++) begin
      logic [DEPTH-1:0] v;
      v = i_rdata[f*DEPTH +: DEPTH] >> i_plane;
      w_bits[f] = v[0];
    end
  end

  assign o_done = i_in_shift && (r_k == K_LAST);

  // Outputs are registered from the next-cycle index so they line up with k exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k       <= '0;
      o_fb_addr <= '0;
      o_sclk    <= 1'b0;
      o_rgb0    <= '0;
      o_rgb1    <= '0;
    end else begin
      r_k    <= w_k_next;
      o_sclk <= i_shift_next && w_k_next[0] && (w_k_next >= K_SCLK0);
      if (i_shift_next && !w_k_next[0] && (w_k_next < K_COLS2))
        o_fb_addr <= {i_row_next, w_k_next[COL_BITS:1]};
      if (i_in_shift && r_k[0] && (r_k < K_COLS2)) begin
        o_rgb0 <= {w_bits[FLD_R0], w_bits[FLD_G0], w_bits[FLD_B0]};
        o_rgb1 <= {w_bits[FLD_R1], w_bits[FLD_G1], w_bits[FLD_B1]};
      end
    end
  end

endmodule

// File: rtl/hub75_bcm_scan.sv
// HUB75 scan driver: per row, for each bit plane, shift the row, latch it and
// hold OE active for a binary-weighted time. Two channels (upper/lower half).
module hub75_bcm_scan
  import hub75_pkg::*;
#(
  parameter int COLS       = 64,
  parameter int SCAN_ROWS  = 16,
  parameter int DEPTH      = 4,
  parameter int BASE_TICKS = 8,
  parameter int COL_BITS   = $clog2(COLS),
  parameter int ROW_BITS   = $clog2(SCAN_ROWS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  output logic [ROW_BITS+COL_BITS-1:0] fb_addr,
  input  logic [6*DEPTH-1:0]           fb_rdata,
  output logic                         sclk,
  output logic                         lat,
  output logic                         oe_n,
  output logic [ROW_BITS-1:0]          row_addr,
  output logic [2:0]                   rgb0,
  output logic [2:0]                   rgb1,
  output logic                         frame_done,
  output state_e                       dbg_state
);

  localparam int PLANE_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = $clog2((BASE_TICKS << (DEPTH - 1)) + 1);

  state_e               r_state, w_state_next;
  logic [ROW_BITS-1:0]  r_row, w_row_next;
  logic [PLANE_W-1:0]   r_plane, w_plane_next;
  logic [CNT_W-1:0]     r_disp_cnt;
  logic                 w_disp_last, w_disp_exit, w_shift_done, w_abort;
  logic                 w_last_plane, w_last_row;

  assign w_disp_last  = (r_disp_cnt == CNT_W'(disp_ticks(BASE_TICKS, int'(r_plane)) - 1));
  assign w_last_plane = (r_plane == PLANE_W'(DEPTH - 1));
  assign w_last_row   = (r_row == ROW_BITS'(SCAN_ROWS - 1));
  assign dbg_state    = r_state;

  // Next-state, plane/row advance and abort handling.
  always_comb begin
    w_state_next = r_state;
    w_row_next   = r_row;
    w_plane_next = r_plane;
    w_disp_exit  = 1'b0;
    w_abort      = (r_state != IDLE) && !en;
    case (r_state)
      IDLE:    if (en) w_state_next = SHIFT;
      SHIFT:   if (!en) w_state_next = IDLE;
               else if (w_shift_done) w_state_next = LATCH;
      LATCH:   w_state_next = en ? DISPLAY : IDLE;
      DISPLAY: if (!en) w_state_next = IDLE;
               else if (w_disp_last) begin
                 w_state_next = SHIFT;
                 w_disp_exit  = 1'b1;
               end
      default: w_state_next = IDLE;
    endcase
    if (w_abort) begin
      w_row_next   = '0;
      w_plane_next = '0;
    end else if (w_disp_exit) begin
      if (w_last_plane) begin
        w_plane_next = '0;
        w_row_next   = w_last_row ? '0 : r_row + ROW_BITS'(1);
      end else begin
        w_plane_next = r_plane + PLANE_W'(1);
      end
    end
  end

  // State, position and display-tick counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_plane    <= '0;
      r_disp_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_row      <= w_row_next;
      r_plane    <= w_plane_next;
      r_disp_cnt <= (r_state == DISPLAY && w_state_next == DISPLAY) ?
                    r_disp_cnt + CNT_W'(1) : '0;
    end
  end

  // Panel control pins, registered from the next state so they match it exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe_n       <= 1'b1;
      lat        <= 1'b0;
      row_addr   <= '0;
      frame_done <= 1'b0;
    end else begin
      oe_n       <= (w_state_next != DISPLAY);
      lat        <= (w_state_next == LATCH);
      if (w_state_next == LATCH) row_addr <= r_row;
      frame_done <= w_disp_exit && w_last_plane && w_last_row;
    end
  end

  hub75_col_shifter #(
    .COLS     (COLS),
    .DEPTH    (DEPTH),
    .ROW_BITS (ROW_BITS),
    .COL_BITS (COL_BITS),
    .PLANE_W  (PLANE_W)
  ) u_shifter (
    .clk          (clk),
    .rst          (rst),
    .i_in_shift   (r_state == SHIFT),
    .i_shift_next (w_state_next == SHIFT),
    .i_row_next   (w_row_next),
    .i_plane      (r_plane),
    .i_rdata      (fb_rdata),
    .o_fb_addr    (fb_addr),
    .o_sclk       (sclk),
    .o_rgb0       (rgb0),
    .o_rgb1       (rgb1),
    .o_done       (w_shift_done)
  );

endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Bench for hub75_bcm_scan: a small instance checked cycle by cycle against a
// position model derived from the row-period arithmetic, plus a default-size
// instance watched by a protocol checker.
module tb_hub75_bcm_scan;
  import hub75_pkg::*;

  localparam int S_C = 4, S_SR = 2, S_D = 2, S_B = 2, S_CB = 2, S_RB = 1;
  localparam int D_C = 64, D_SR = 16, D_D = 4, D_B = 8, D_CB = 6, D_RB = 4;

  typedef struct packed { int phase; int row; int plane; int k; } pos_t;

  logic clk;
  logic rst_s, en_s, rst_d, en_d;
  logic [S_RB+S_CB-1:0] fb_addr_s;
  logic [6*S_D-1:0]     rdata_s;
  logic                 sclk_s, lat_s, oe_n_s, fd_s;
  logic [S_RB-1:0]      row_addr_s;
  logic [2:0]           rgb0_s, rgb1_s;
  state_e               dbg_s;
  logic [D_RB+D_CB-1:0] fb_addr_d;
  logic [6*D_D-1:0]     rdata_d;
  logic                 sclk_d, lat_d, oe_n_d, fd_d;
  logic [D_RB-1:0]      row_addr_d;
  logic [2:0]           rgb0_d, rgb1_d;
  state_e               dbg_d;

  logic [6*S_D-1:0] mem_s [S_SR*S_C];
  logic [6*D_D-1:0] mem_d [D_SR*D_C];
  logic [S_RB-1:0]  exp_latched_s;
  int n_pass, n_total;

  hub75_bcm_scan #(.COLS(S_C), .SCAN_ROWS(S_SR), .DEPTH(S_D), .BASE_TICKS(S_B)) dut_s (
    .clk(clk), .rst(rst_s), .en(en_s), .fb_addr(fb_addr_s), .fb_rdata(rdata_s),
    .sclk(sclk_s), .lat(lat_s), .oe_n(oe_n_s), .row_addr(row_addr_s),
    .rgb0(rgb0_s), .rgb1(rgb1_s), .frame_done(fd_s), .dbg_state(dbg_s));

  hub75_bcm_scan dut_d (
    .clk(clk), .rst(rst_d), .en(en_d), .fb_addr(fb_addr_d), .fb_rdata(rdata_d),
    .sclk(sclk_d), .lat(lat_d), .oe_n(oe_n_d), .row_addr(row_addr_d),
    .rgb0(rgb0_d), .rgb1(rgb1_d), .frame_done(fd_d), .dbg_state(dbg_d));

  // clock / memory models
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) rdata_s <= mem_s[fb_addr_s];
  always @(posedge clk) rdata_d <= mem_d[fb_addr_d];

  // Where in the frame cycle t (counted from the first SHIFT cycle) falls.
  function automatic pos_t locate(input int t, input int c, input int sr, input int d, input int b);
    pos_t q;
    int per_row, r, seg;
    bit found;
    per_row = d * (2*c + 3) + b * ((1 << d) - 1);
    r = t % (per_row * sr);
    q.row = r / per_row;
    r = r % per_row;
    q.plane = 0; q.k = 0; q.phase = 0;
    found = 1'b0;
    for (int p = 0; p < d; p++) begin
      seg = 2*c + 3 + (b << p);
      if (!found) begin
        if (r < seg) begin q.plane = p; found = 1'b1; end
        else r -= seg;
      end
    end
    if (r < 2*c + 2) begin q.phase = 0; q.k = r; end
    else if (r == 2*c + 2) q.phase = 1;
    else begin q.phase = 2; q.k = r - (2*c + 3); end
    return q;
  endfunction

  // Check the small instance for n cycles; en must have just been raised from IDLE.
  task automatic run_small(input int n, input bit directed);
    pos_t q;
    int fr;
    logic [6*S_D-1:0] w;
    logic [2:0] e0, e1;
    logic [S_RB+S_CB-1:0] ea;
    logic es, el, eo, ef;
    fr = S_SR * (S_D*(2*S_C+3) + S_B*((1<<S_D)-1));
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      q = locate(t, S_C, S_SR, S_D, S_B);
      if (q.phase == 1) exp_latched_s = S_RB'(q.row);
      es = (q.phase == 0) && (q.k % 2 == 1) && (q.k >= 3);
      el = (q.phase == 1);
      eo = (q.phase != 2);
      ef = (t > 0) && (t % fr == 0);
      n_total++; if (sclk_s !== es) $display("FAIL sclk t=%0d got %b exp %b", t, sclk_s, es); else n_pass++;
      n_total++; if (lat_s !== el) $display("FAIL lat t=%0d got %b exp %b", t, lat_s, el); else n_pass++;
      n_total++; if (oe_n_s !== eo) $display("FAIL oe_n t=%0d got %b exp %b", t, oe_n_s, eo); else n_pass++;
      n_total++; if (fd_s !== ef) $display("FAIL frame_done t=%0d got %b exp %b", t, fd_s, ef); else n_pass++;
      n_total++;
      if (row_addr_s !== exp_latched_s) $display("FAIL row_addr t=%0d got %0d exp %0d", t, row_addr_s, exp_latched_s);
      else n_pass++;
      if (q.phase == 0 && q.k % 2 == 0 && q.k < 2*S_C) begin
        ea = (S_RB+S_CB)'(q.row * S_C + q.k / 2);
        n_total++; if (fb_addr_s !== ea) $display("FAIL fb_addr t=%0d got %0d exp %0d", t, fb_addr_s, ea); else n_pass++;
      end
      if (es) begin
        w  = mem_s[q.row * S_C + (q.k - 3) / 2];
        e0 = {w[2*S_D+q.plane], w[S_D+q.plane], w[q.plane]};
        e1 = {w[5*S_D+q.plane], w[4*S_D+q.plane], w[3*S_D+q.plane]};
        n_total++; if (rgb0_s !== e0) $display("FAIL rgb0 t=%0d got %b exp %b", t, rgb0_s, e0); else n_pass++;
        n_total++; if (rgb1_s !== e1) $display("FAIL rgb1 t=%0d got %b exp %b", t, rgb1_s, e1); else n_pass++;
      end
      if (directed && (t == 7 || t == 20)) begin
        e0 = (t == 7) ? 3'b000 : 3'b100;
        e1 = (t == 7) ? 3'b001 : 3'b000;
        n_total++;
        if (rgb0_s !== e0 || rgb1_s !== e1)
          $display("FAIL col2_pixel t=%0d got %b/%b exp %b/%b", t, rgb0_s, rgb1_s, e0, e1);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset;
    rst_s = 1'b1; rst_d = 1'b1; en_s = 1'b0; en_d = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({sclk_s, lat_s, oe_n_s, fd_s, row_addr_s, rgb0_s, rgb1_s, fb_addr_s} !== {3'b001, 1'b0, 10'd0})
      $display("FAIL reset_small got sclk=%b lat=%b oe_n=%b fd=%b row=%0d rgb=%b/%b addr=%0d",
               sclk_s, lat_s, oe_n_s, fd_s, row_addr_s, rgb0_s, rgb1_s, fb_addr_s);
    else n_pass++;
    n_total++;
    if ({sclk_d, lat_d, oe_n_d, fd_d, row_addr_d, rgb0_d, rgb1_d, fb_addr_d} !== {3'b001, 1'b0, 20'd0})
      $display("FAIL reset_default got sclk=%b lat=%b oe_n=%b fd=%b row=%0d rgb=%b/%b addr=%0d",
               sclk_d, lat_d, oe_n_d, fd_d, row_addr_d, rgb0_d, rgb1_d, fb_addr_d);
    else n_pass++;
    rst_s = 1'b0; rst_d = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_total++;
      if (dbg_s !== IDLE || oe_n_s !== 1'b1 || sclk_s !== 1'b0)
        $display("FAIL idle_hold got state=%0d oe_n=%b sclk=%b exp 0/1/0", dbg_s, oe_n_s, sclk_s);
      else n_pass++;
    end
  endtask

  task automatic test_first_frame;
    en_s = 1'b1;
    run_small(2 * 56 + 1, 1'b1);
  endtask

  // Abort inside plane-1 DISPLAY of row 1, then restart from row 0 plane 0.
  task automatic test_abort;
    en_s = 1'b0;
    repeat (2) @(negedge clk);
    en_s = 1'b1;
    run_small(54, 1'b0);
    en_s = 1'b0;
    repeat (4) begin
      @(negedge clk);
      n_total++;
      if (oe_n_s !== 1'b1 || sclk_s !== 1'b0 || lat_s !== 1'b0 || dbg_s !== IDLE || row_addr_s !== exp_latched_s)
        $display("FAIL abort_idle got oe_n=%b sclk=%b lat=%b state=%0d row=%0d exp 1/0/0/0/%0d",
                 oe_n_s, sclk_s, lat_s, dbg_s, row_addr_s, exp_latched_s);
      else n_pass++;
    end
    en_s = 1'b1;
    run_small(28, 1'b0);
  endtask

  task automatic test_reset_mid_shift;
    en_s = 1'b0;
    repeat (2) @(negedge clk);
    en_s = 1'b1;
    run_small(6, 1'b0);
    rst_s = 1'b1;
    #1;
    n_total++;
    if (sclk_s !== 1'b0 || oe_n_s !== 1'b1 || lat_s !== 1'b0 || rgb0_s !== 3'd0 || rgb1_s !== 3'd0 || fb_addr_s !== '0)
      $display("FAIL async_rst got sclk=%b oe_n=%b lat=%b rgb=%b/%b addr=%0d exp 0/1/0/000/000/0",
               sclk_s, oe_n_s, lat_s, rgb0_s, rgb1_s, fb_addr_s);
    else n_pass++;
    en_s = 1'b0;
    exp_latched_s = '0;
    @(negedge clk);
    rst_s = 1'b0;
    @(negedge clk);
    n_total++;
    if (dbg_s !== IDLE || oe_n_s !== 1'b1) $display("FAIL post_rst got state=%0d oe_n=%b exp 0/1", dbg_s, oe_n_s);
    else n_pass++;
    en_s = 1'b1;
    run_small(28, 1'b0);
    en_s = 1'b0;
  endtask

  // Default-size instance: protocol checker over one whole frame.
  task automatic test_default_checker;
    int fr, sclk_cnt, oe_len, win, lats, fds;
    logic prev_oe;
    pos_t q;
    logic [6*D_D-1:0] w;
    logic [2:0] e0, e1;
    fr = D_SR * (D_D*(2*D_C+3) + D_B*((1<<D_D)-1));
    sclk_cnt = 0; oe_len = 0; win = 0; lats = 0; fds = 0; prev_oe = 1'b1;
    en_d = 1'b1;
    for (int t = 0; t <= fr; t++) begin
      @(negedge clk);
      if (oe_n_d === 1'b0) begin
        n_total++;
        if (sclk_d !== 1'b0 || lat_d !== 1'b0) $display("FAIL dark_pins t=%0d sclk=%b lat=%b exp 0/0", t, sclk_d, lat_d);
        else n_pass++;
        oe_len++;
      end else if (prev_oe === 1'b0) begin
        n_total++;
        if (oe_len != (D_B << (win % D_D))) $display("FAIL oe_window %0d got %0d exp %0d", win, oe_len, D_B << (win % D_D));
        else n_pass++;
        win++; oe_len = 0;
      end
      prev_oe = oe_n_d;
      if (sclk_d === 1'b1) begin
        sclk_cnt++;
        q  = locate(t, D_C, D_SR, D_D, D_B);
        w  = mem_d[q.row * D_C + (q.k - 3) / 2];
        e0 = {w[2*D_D+q.plane], w[D_D+q.plane], w[q.plane]};
        e1 = {w[5*D_D+q.plane], w[4*D_D+q.plane], w[3*D_D+q.plane]};
        n_total++;
        if (rgb0_d !== e0 || rgb1_d !== e1) $display("FAIL rgb_default t=%0d got %b/%b exp %b/%b", t, rgb0_d, rgb1_d, e0, e1);
        else n_pass++;
      end
      if (lat_d === 1'b1) begin
        n_total++;
        if (sclk_cnt != D_C) $display("FAIL sclk_per_lat got %0d exp %0d", sclk_cnt, D_C); else n_pass++;
        sclk_cnt = 0; lats++;
      end
      if (fd_d === 1'b1) fds++;
    end
    n_total++; if (win != D_SR * D_D) $display("FAIL oe_windows got %0d exp %0d", win, D_SR * D_D); else n_pass++;
    n_total++; if (lats != D_SR * D_D) $display("FAIL lat_count got %0d exp %0d", lats, D_SR * D_D); else n_pass++;
    n_total++; if (fds != 1 || fd_d !== 1'b1) $display("FAIL frame_done_default got count=%0d last=%b exp 1/1", fds, fd_d);
    else n_pass++;
    en_d = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_s = 1'b1; rst_d = 1'b1; en_s = 1'b0; en_d = 1'b0;
    exp_latched_s = '0;
    for (int i = 0; i < S_SR*S_C; i++) mem_s[i] = (6*S_D)'($urandom);
    mem_s[2] = 12'h060;
    for (int i = 0; i < D_SR*D_C; i++) mem_d[i] = (6*D_D)'($urandom);
    test_reset;
    test_first_frame;
    test_abort;
    test_reset_mid_shift;
    test_default_checker;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
